sdram_ring_fifo: RTL

Upstream client of the SDRAM controller. Turns the SDRAM into a large word-wide FIFO: a capture-side stream is buffered in a small input FIFO and written to SDRAM in fixed-length bursts, and bursts are read back in order into a small output FIFO that feeds the host-side stream. The block owns the SDRAM ring pointers, the fill level, write/read arbitration, and the full request/data handshake toward the controller.

---
 rtl/sdram_ring_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_ring_fifo.sv
// SDRAM-backed word FIFO: buffers a capture stream, moves fixed-length bursts
// through a ring in SDRAM, and replays them in order to the host stream.
module sdram_ring_fifo #(
    parameter int unsigned DQ_WIDTH  = 16,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned RING_AW   = 24,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned IN_AW     = 6,
    parameter int unsigned OUT_AW    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DQ_WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DQ_WIDTH-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                ovf_clr,
    output logic                overflow,
    output logic [RING_AW:0]    level,
    output logic                app_req,
    input  logic                app_req_ack,
    output logic                app_wr,
    output logic [7:0]          app_req_len,
    output logic [31:0]         app_req_addr,
    output logic [DQ_WIDTH-1:0] app_wr_data,
    input  logic                app_wr_next_req,
    input  logic [DQ_WIDTH-1:0] app_rd_data,
    input  logic                app_rd_ready
);
    localparam int unsigned IN_DEPTH  = 1 << IN_AW;
    localparam int unsigned OUT_DEPTH = 1 << OUT_AW;
    localparam int unsigned ICW       = IN_AW + 1;
    localparam int unsigned OCW       = OUT_AW + 1;
    localparam int unsigned PW        = RING_AW + 1;
    localparam logic [PW-1:0] BURST_P  = PW'(BURST_LEN);
    localparam logic [PW-1:0] WR_LIMIT = PW'((64'(1) << RING_AW) - 64'(BURST_LEN));

    typedef enum logic [1:0] {IDLE, REQ, WR_XFER, RD_XFER} state_t;

    state_t state, state_d;

    // Input FIFO
    logic [DQ_WIDTH-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]    in_wr_idx, in_rd_idx;
    logic [ICW-1:0]      in_cnt, in_cnt_d;
    logic                in_push, in_pop;

    assign in_push     = in_valid && in_ready;
    assign in_pop      = (state == WR_XFER) && app_wr_next_req;
    assign in_cnt_d    = in_cnt + ICW'(in_push) - ICW'(in_pop);
    assign app_wr_data = in_mem[in_rd_idx];

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr_idx] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wr_idx <= '0;
            in_rd_idx <= '0;
            in_cnt    <= '0;
            in_ready  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_push) in_wr_idx <= in_wr_idx + IN_AW'(1);
            if (in_pop)  in_rd_idx <= in_rd_idx + IN_AW'(1);
            in_cnt   <= in_cnt_d;
            in_ready <= (in_cnt_d != ICW'(IN_DEPTH));
            if (in_valid && !in_ready) overflow <= 1'b1;
            else if (ovf_clr)          overflow <= 1'b0;
        end
    end

    // Output FIFO
    logic [DQ_WIDTH-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]   out_wr_idx, out_rd_idx;
    logic [OCW-1:0]      out_cnt, out_cnt_d;
    logic                out_push, out_pop;

    assign out_push  = (state == RD_XFER) && app_rd_ready;
    assign out_pop   = out_valid && out_ready;
    assign out_cnt_d = out_cnt + OCW'(out_push) - OCW'(out_pop);
    assign out_data  = out_mem[out_rd_idx];

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wr_idx] <= app_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr_idx <= '0;
            out_rd_idx <= '0;
            out_cnt    <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (out_push) out_wr_idx <= out_wr_idx + OUT_AW'(1);
            if (out_pop)  out_rd_idx <= out_rd_idx + OUT_AW'(1);
            out_cnt   <= out_cnt_d;
            out_valid <= (out_cnt_d != '0);
        end
    end

    // Ring pointers, arbitration and controller handshake
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [31:0]   app_req_addr_d;
    logic          app_req_d, app_wr_d, last_rd, last_rd_d;
    logic          wr_next_q, rd_ready_q;
    logic          wr_elig, rd_elig;

    function automatic logic [31:0] ring_addr(input logic [PW-1:0] p);
        return 32'(BASE_ADDR) + 32'(p[RING_AW-1:0]);
    endfunction

    assign app_req_len = 8'(BURST_LEN - 1);
    assign wr_elig     = (in_cnt >= ICW'(BURST_LEN)) && (level <= WR_LIMIT);
    assign rd_elig     = (level >= BURST_P) && (out_cnt <= OCW'(OUT_DEPTH - BURST_LEN));

    always_comb begin
        state_d        = state;
        app_req_d      = app_req;
        app_wr_d       = app_wr;
        app_req_addr_d = app_req_addr;
        wr_ptr_d       = wr_ptr;
        rd_ptr_d       = rd_ptr;
        last_rd_d      = last_rd;
        case (state)
            IDLE: begin
                // On contention, alternate against the last completed direction
                if (wr_elig && (!rd_elig || last_rd)) begin
                    app_wr_d       = 1'b0;
                    app_req_addr_d = ring_addr(wr_ptr);
                    app_req_d      = 1'b1;
                    state_d        = REQ;
                end else if (rd_elig) begin
                    app_wr_d       = 1'b1;
                    app_req_addr_d = ring_addr(rd_ptr);
                    app_req_d      = 1'b1;
                    state_d        = REQ;
                end
            end
            REQ: begin
                if (app_req_ack) begin
                    app_req_d = 1'b0;
                    state_d   = app_wr ? RD_XFER : WR_XFER;
                end
            end
            WR_XFER: begin
                if (wr_next_q && !app_wr_next_req) begin
                    wr_ptr_d  = wr_ptr + BURST_P;
                    last_rd_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_XFER: begin
                if (rd_ready_q && !app_rd_ready) begin
                    rd_ptr_d  = rd_ptr + BURST_P;
                    last_rd_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            app_req      <= 1'b0;
            app_wr       <= 1'b1;
            app_req_addr <= 32'(BASE_ADDR);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            last_rd      <= 1'b1;
            wr_next_q    <= 1'b0;
            rd_ready_q   <= 1'b0;
        end else begin
            state        <= state_d;
            app_req      <= app_req_d;
            app_wr       <= app_wr_d;
            app_req_addr <= app_req_addr_d;
            wr_ptr       <= wr_ptr_d;
            rd_ptr       <= rd_ptr_d;
            level        <= wr_ptr_d - rd_ptr_d;
            last_rd      <= last_rd_d;
            wr_next_q    <= app_wr_next_req;
            rd_ready_q   <= app_rd_ready;
        end
    end
endmodule
